sha1_arbiter: RTL and testbench

Round-robin arbiter and block sequencer that shares one `sha_1` hash core between `NREQ` requesters. It locks the core to one requester for a whole multi-block message, so the core's chaining state is never interleaved. It generates the core's `Index`, `Enable` and `Data`, and returns the final 160-bit digest to the owning requester. It sits between the requester ports and a single `sha_1` instance in the hashing subsystem.

---
 rtl/sha1_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sha1_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_arbiter.sv
// sha1_arbiter
//   Round-robin arbiter and block sequencer sharing one sha_1 core between
//   NREQ requesters. A requester keeps the core for a whole multi-block
//   message so the core's chaining state is never interleaved.
//
// Parameters
//   NREQ     number of requesters (2..16)
//   TIMEOUT  HOLD watchdog limit in cycles (only with SHA1_ARB_WDT_EN)
//
// Optional feature macro
//   SHA1_ARB_WDT_EN  enables the HOLD-state watchdog (err / err_id);
//                    undefined: HOLD waits forever, err/err_id tied 0.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   req_valid/data/first/last  per-requester block offer (512 bits each)
//   req_ready         one-hot accept strobe (combinational)
//   resp_valid        one-hot one-cycle digest strobe
//   resp_hash         final digest, held until the next response
//   err, err_id       one-cycle watchdog abort pulse and aborted requester
//   core_data/index/enable  drive the core's Data/Index/Enable
//   core_hash/ready   core's Hash/Ready
module sha1_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*512-1:0] req_data,
    input  logic [NREQ-1:0]     req_first,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     resp_valid,
    output logic [159:0]        resp_hash,
    output logic                err,
    output logic [3:0]          err_id,
    output logic [511:0]        core_data,
    output logic [63:0]         core_index,
    output logic                core_enable,
    input  logic [159:0]        core_hash,
    input  logic                core_ready
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {ARB, ISSUE, BUSY, HOLD} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, owner, gnt_id, sel, ptr_inc;
    logic          gnt_any, accept, done, wdt_expire;
    logic          last;
    logic [63:0]   cnt;
    logic [511:0]  blk;
    logic          blk_first, blk_last;

    // Round-robin search starting at ptr, wrapping at NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr) + k) % 32'(NREQ);
            if (!gnt_any && req_valid[idx[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[IW-1:0];
            end
        end
    end

    assign sel     = (state == ARB) ? gnt_id : owner;
    assign ptr_inc = (32'(owner) == 32'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        blk       = '0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (i == 32'(sel)) begin
                blk       = req_data[i*512 +: 512];
                blk_first = req_first[i];
                blk_last  = req_last[i];
            end
        end
    end

    always_comb begin
        unique case (state)
            ARB:     accept = gnt_any;
            HOLD:    accept = req_valid[owner];
            default: accept = 1'b0;
        endcase
    end

    assign done = (state == BUSY) && core_ready && last;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= ARB;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            ARB:   if (accept) state_nx = ISSUE;
            ISSUE: state_nx = BUSY;
            BUSY:  if (core_ready) state_nx = last ? ARB : HOLD;
            HOLD: begin
                // an accept in the expiry cycle wins over the abort
                if (accept)          state_nx = ISSUE;
                else if (wdt_expire) state_nx = ARB;
            end
            default: state_nx = ARB;
        endcase
    end

    // Outputs decoded from the registered state; gated by rst so nothing
    // is offered while reset is held.
    always_comb begin
        req_ready   = '0;
        core_enable = 1'b0;
        core_index  = '0;
        if (rst) begin
            unique case (state)
                ARB:  if (gnt_any) req_ready[gnt_id] = 1'b1;
                HOLD: req_ready[owner] = 1'b1;
                ISSUE: begin
                    core_enable = 1'b1;
                    core_index  = cnt;
                end
                default: ;
            endcase
        end
    end

    // Datapath: owner, block counter, data and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
            last       <= 1'b0;
            core_data  <= '0;
            resp_hash  <= '0;
            resp_valid <= '0;
        end else begin
            resp_valid <= '0;
            if (accept) begin
                core_data <= blk;
                last      <= blk_last;
                if (state == ARB) begin
                    owner <= gnt_id;
                    cnt   <= 64'd1;
                end else if (blk_first) begin
                    cnt <= 64'd1;
                end else if (cnt != '1) begin
                    cnt <= cnt + 64'd1;
                end
            end
            if (done) begin
                resp_hash         <= core_hash;
                resp_valid[owner] <= 1'b1;
                ptr               <= ptr_inc;
            end
            if (wdt_expire && !accept) ptr <= ptr_inc;
        end
    end

`ifdef SHA1_ARB_WDT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wdt;
    logic          err_r;
    logic [3:0]    err_id_r;

    // wdt holds 0 outside HOLD, so it is cleared on every entry to HOLD
    assign wdt_expire = (state == HOLD) && !accept && (wdt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt      <= '0;
            err_r    <= 1'b0;
            err_id_r <= '0;
        end else begin
            err_r    <= wdt_expire;
            err_id_r <= wdt_expire ? 4'(owner) : '0;
            if (state != HOLD)  wdt <= '0;
            else if (wdt != '1) wdt <= wdt + 1'b1;
        end
    end

    assign err    = err_r;
    assign err_id = err_id_r;
`else
    assign wdt_expire = 1'b0;
    assign err        = 1'b0;
    assign err_id     = '0;
`endif

endmodule

// File: tb/tb_sha1_arbiter.sv
// tb_sha1_arbiter
//   Self-checking bench for sha1_arbiter. A behavioural stand-in for the
//   sha_1 core raises Ready 160 cycles after Enable; its Hash is a simple
//   chaining sum of the low 160 bits of each block (reset on Index==1), so
//   expected digests are easy to derive by hand.
module tb_sha1_arbiter;
    localparam int NREQ = 4;
    localparam int TOUT = 16;
    localparam logic [351:0] PAD = {11{32'hc3c3_5a5a}};

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*512-1:0] req_data;
    logic [NREQ-1:0]     req_first;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     resp_valid;
    logic [159:0]        resp_hash;
    logic                err;
    logic [3:0]          err_id;
    logic [511:0]        core_data;
    logic [63:0]         core_index;
    logic                core_enable;
    logic [159:0]        core_hash;
    logic                core_ready;

    sha1_arbiter #(.NREQ(NREQ), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_first(req_first), .req_last(req_last), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_hash(resp_hash),
        .err(err), .err_id(err_id),
        .core_data(core_data), .core_index(core_index), .core_enable(core_enable),
        .core_hash(core_hash), .core_ready(core_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in
    int unsigned  mk_cnt;
    logic [159:0] chain;
    always @(posedge clk) begin
        if (!rst) begin
            mk_cnt     <= 0;
            core_ready <= 1'b0;
            chain      <= '0;
        end else begin
            core_ready <= 1'b0;
            if (core_enable) begin
                mk_cnt <= 159;
                chain  <= ((core_index == 64'd1) ? 160'd0 : chain) + core_data[159:0];
            end else if (mk_cnt != 0) begin
                mk_cnt     <= mk_cnt - 1;
                core_ready <= (mk_cnt == 1);
            end
        end
    end
    assign core_hash = core_ready ? chain : {5{32'hdeadbeef}};

    // Scoreboard bookkeeping
    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [159:0] low;
        logic         first;
        logic         last;
    } blk_t;

    typedef struct {
        int              cyc;
        int              id;
        logic [159:0]    val;
        logic [NREQ-1:0] oh;
    } ev_t;

    blk_t            rq[NREQ][$];
    ev_t             acc_q[$], en_q[$], resp_q[$], err_q[$];
    logic [NREQ-1:0] acc_flag = '0;
    bit              rnd_mode = 1'b1;
    int              viol = 0;

    function automatic blk_t mk_blk(input logic [159:0] low, input logic f, input logic l);
        blk_t b;
        b.low = low; b.first = f; b.last = l;
        return b;
    endfunction

    function automatic ev_t mk_ev(input int c, input int id, input logic [159:0] v,
                                  input logic [NREQ-1:0] oh);
        ev_t e;
        e.cyc = c; e.id = id; e.val = v; e.oh = oh;
        return e;
    endfunction

    function automatic int oh2id(input logic [NREQ-1:0] oh);
        for (int i = NREQ - 1; i >= 0; i--) if (oh[i]) return i;
        return -1;
    endfunction

    // Requester driver: presents the head of each queue; pops on accept.
    initial begin
        req_valid = '0; req_data = '0; req_first = '0; req_last = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_flag[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rnd_mode) begin
                    req_valid[i]            = 1'($urandom_range(0, 1));
                    req_first[i]            = 1'($urandom_range(0, 1));
                    req_last[i]             = 1'($urandom_range(0, 1));
                    req_data[i*512 +: 512]  = {16{$urandom()}};
                end else if (rq[i].size() > 0) begin
                    req_valid[i]            = 1'b1;
                    req_first[i]            = rq[i][0].first;
                    req_last[i]             = rq[i][0].last;
                    req_data[i*512 +: 512]  = {PAD, rq[i][0].low};
                end else begin
                    req_valid[i]            = 1'b0;
                    req_first[i]            = 1'b0;
                    req_last[i]             = 1'b0;
                    req_data[i*512 +: 512]  = '0;
                end
            end
        end
    end

    // Event monitor, sampled mid-cycle
    always @(negedge clk) begin
        acc_flag = req_valid & req_ready;
        if (rst) begin
            if ($countones(req_ready) > 1 || $countones(resp_valid) > 1) viol++;
            if (core_enable && (mk_cnt != 0 || core_ready)) viol++;
            if (core_enable && core_data[511:160] !== PAD) viol++;
            if (|acc_flag)   acc_q.push_back(mk_ev(cyc, oh2id(acc_flag), '0, acc_flag));
            if (core_enable) en_q.push_back(mk_ev(cyc, 0, 160'(core_index), '0));
            if (|resp_valid) resp_q.push_back(mk_ev(cyc, oh2id(resp_valid), resp_hash, resp_valid));
            if (err)         err_q.push_back(mk_ev(cyc, int'(err_id), '0, '0));
        end
    end

    task automatic clear_logs();
        acc_q.delete(); en_q.delete(); resp_q.delete(); err_q.delete();
    endtask

    task automatic wait_resp(input int n, input int maxc);
        int k = 0;
        while (resp_q.size() < n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("wait_resp", resp_q.size(), n);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int              id;
        logic [159:0]    low;
        logic [NREQ-1:0] exp_oh;
        logic [159:0]    exp_hash;
    } vec_t;

    vec_t vt[4];

    initial begin
        vt[0] = '{2, 160'h6162_6380, 4'b0100, 160'h6162_6380};
        vt[1] = '{1, 160'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f0f_0f0f, 4'b0010,
                     160'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f0f_0f0f};
        vt[2] = '{0, 160'hffff_ffff_0000_0000_ffff_ffff_0000_0000_ffff_ffff, 4'b0001,
                     160'hffff_ffff_0000_0000_ffff_ffff_0000_0000_ffff_ffff};
        vt[3] = '{3, 160'h1, 4'b1000, 160'h1};

        // Reset held with random requester activity
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_outputs",
                160'({req_ready, resp_valid, err, err_id, core_enable,
                      |core_data, |core_index, |resp_hash}), '0);
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);

        // Single-block messages, one requester at a time
        for (int v = 0; v < 4; v++) begin
            clear_logs();
            rq[vt[v].id].push_back(mk_blk(vt[v].low, 1'b1, 1'b1));
            wait_resp(1, 400);
            if (resp_q.size() > 0 && acc_q.size() > 0 && en_q.size() > 0) begin
                chk("tbl_grant_id",  acc_q[0].id, vt[v].id);
                chk("tbl_resp_oh",   resp_q[0].oh, vt[v].exp_oh);
                chk("tbl_hash",      resp_q[0].val, vt[v].exp_hash);
                chk("tbl_index",     en_q[0].val, 1);
                chk("tbl_enable_at", en_q[0].cyc - acc_q[0].cyc, 1);
                chk("tbl_latency",   resp_q[0].cyc - acc_q[0].cyc, 162);
            end
        end

        // All four valid: grant order 0,1,2,3,0 from ptr=0
        clear_logs();
        rq[0].push_back(mk_blk(160'ha0, 1'b1, 1'b1));
        rq[0].push_back(mk_blk(160'he0, 1'b1, 1'b1));
        rq[1].push_back(mk_blk(160'hb0, 1'b1, 1'b1));
        rq[2].push_back(mk_blk(160'hc0, 1'b1, 1'b1));
        rq[3].push_back(mk_blk(160'hd0, 1'b1, 1'b1));
        wait_resp(5, 1000);
        begin
            int          ord[5]  = '{0, 1, 2, 3, 0};
            logic [159:0] hx[5]  = '{160'ha0, 160'hb0, 160'hc0, 160'hd0, 160'he0};
            if (resp_q.size() >= 5 && acc_q.size() >= 5) begin
                for (int k = 0; k < 5; k++) begin
                    chk("rr_grant_id", acc_q[k].id, ord[k]);
                    chk("rr_resp_id",  resp_q[k].id, ord[k]);
                    chk("rr_hash",     resp_q[k].val, hx[k]);
                    chk("rr_latency",  resp_q[k].cyc - acc_q[k].cyc, 162);
                end
            end
        end

        // Realign ptr to 0 via requester 3
        clear_logs();
        rq[3].push_back(mk_blk(160'hf0, 1'b1, 1'b1));
        wait_resp(1, 400);
        if (resp_q.size() > 0) chk("align_resp_id", resp_q[0].id, 3);

        // Two-block message on 0 while 1 is continuously valid
        clear_logs();
        rq[1].push_back(mk_blk(160'h1234, 1'b1, 1'b1));
        rq[0].push_back(mk_blk(160'h8000_0000_0000_0000_0000_0000_0000_0000_ffff_ffff, 1'b1, 1'b0));
        rq[0].push_back(mk_blk(160'h0000_0001_0000_0000_0000_0000_0000_0000_0000_0001, 1'b0, 1'b1));
        wait_resp(2, 800);
        if (acc_q.size() >= 3 && en_q.size() >= 3 && resp_q.size() >= 2) begin
            chk("two_acc_ids",  {acc_q[0].id[3:0], acc_q[1].id[3:0], acc_q[2].id[3:0]}, 12'h001);
            chk("two_index1",   en_q[0].val, 1);
            chk("two_index2",   en_q[1].val, 2);
            chk("two_blk2_at",  acc_q[1].cyc - acc_q[0].cyc, 162);
            chk("two_resp_id",  resp_q[0].id, 0);
            chk("two_hash",     resp_q[0].val,
                160'h8000_0001_0000_0000_0000_0000_0000_0001_0000_0000);
            chk("two_latency",  resp_q[0].cyc - acc_q[1].cyc, 162);
            chk("two_r1_after", acc_q[2].cyc - resp_q[0].cyc, 0);
            chk("two_r1_hash",  resp_q[1].val, 160'h1234);
        end

        // req_first in HOLD restarts the message (requester 2, ptr=2)
        clear_logs();
        rq[2].push_back(mk_blk(160'haaaa, 1'b1, 1'b0));
        rq[2].push_back(mk_blk(160'h5555, 1'b1, 1'b1));
        wait_resp(1, 600);
        if (en_q.size() >= 2 && resp_q.size() >= 1) begin
            chk("restart_index2", en_q[1].val, 1);
            chk("restart_id",     resp_q[0].id, 2);
            chk("restart_hash",   resp_q[0].val, 160'h5555);
        end

        // Owner 3 stalls after block 1 of 2; requester 0 waits
        clear_logs();
        rq[3].push_back(mk_blk(160'h5, 1'b1, 1'b0));
        rq[0].push_back(mk_blk(160'h99, 1'b1, 1'b1));
`ifdef SHA1_ARB_WDT_EN
        begin
            int k = 0;
            while (err_q.size() == 0 && k < 400) begin
                @(negedge clk);
                k++;
            end
        end
        chk("wdt_err_seen", err_q.size(), 1);
        chk("wdt_no_resp",  resp_q.size(), 0);
        if (err_q.size() > 0 && acc_q.size() > 0) begin
            chk("wdt_err_id",   err_q[0].id, 3);
            chk("wdt_err_time", 160'((err_q[0].cyc - acc_q[0].cyc >= 162 + TOUT) &&
                                     (err_q[0].cyc - acc_q[0].cyc <= 163 + TOUT)), 1);
        end
        wait_resp(1, 400);
        if (resp_q.size() > 0 && acc_q.size() > 1) begin
            chk("wdt_next_grant", acc_q[1].id, 0);
            chk("wdt_next_hash",  resp_q[0].val, 160'h99);
        end
`else
        repeat (250) @(negedge clk);
        chk("hold_no_err",   err_q.size(), 0);
        chk("hold_locked",   acc_q.size(), 1);
        rq[3].push_back(mk_blk(160'h7, 1'b0, 1'b1));
        wait_resp(1, 400);
        if (resp_q.size() > 0) begin
            chk("hold_resp_id", resp_q[0].id, 3);
            chk("hold_hash",    resp_q[0].val, 160'hc);
        end
        wait_resp(2, 400);
        if (resp_q.size() > 1) chk("hold_next_id", resp_q[1].id, 0);
`endif

        chk("invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
